// File: rtl/vm_input_conditioner.sv
// Input conditioner for the vending machine: synchronises, debounces and edge-detects
// ten raw inputs, then latches each press per group until the consumer samples it.
module vm_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] coin_raw,
  input  logic [3:0] select_raw,
  input  logic       confirm_raw,
  input  logic       reset_total_raw,
  input  logic       consume_tick,
  output logic [3:0] coin_evt,
  output logic [3:0] select_evt,
  output logic       confirm_evt,
  output logic       reset_total_evt,
  output logic       overrun
);

  localparam int N_IN = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit layout shared by all per-input vectors: {reset_total, confirm, select[3:0], coin[3:0]}
  logic [N_IN-1:0]  raw_all;
  logic [N_IN-1:0]  sync1_q, sync1_d;
  logic [N_IN-1:0]  sync2_q, sync2_d;
  logic [N_IN-1:0]  stable_q, stable_d;
  logic [N_IN-1:0]  press;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];

  logic [3:0] coin_pend_q, coin_pend_d;
  logic [3:0] select_pend_q, select_pend_d;
  logic       confirm_pend_q, confirm_pend_d;
  logic       reset_total_pend_q, reset_total_pend_d;
  logic       overrun_q, overrun_d;

  logic [3:0] coin_win, select_win;
  logic       coin_disc, select_disc, confirm_disc, reset_total_disc;

  function automatic logic [3:0] lowest4(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  function automatic logic multi4(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  assign raw_all = {reset_total_raw, confirm_raw, select_raw, coin_raw};

  // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    sync1_d  = raw_all;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press    = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          press[i]    = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Pending update: an empty slot always loads; a full slot only turns over on a tick.
  always_comb begin
    coin_win         = lowest4(press[3:0]);
    select_win       = lowest4(press[7:4]);
    coin_disc        = multi4(press[3:0]);
    select_disc      = multi4(press[7:4]);
    confirm_disc     = 1'b0;
    reset_total_disc = 1'b0;

    coin_pend_d = coin_pend_q;
    if (coin_pend_q == 4'd0 || consume_tick) begin
      coin_pend_d = coin_win;
    end else if (coin_win != 4'd0) begin
      coin_disc = 1'b1;
    end

    select_pend_d = select_pend_q;
    if (select_pend_q == 4'd0 || consume_tick) begin
      select_pend_d = select_win;
    end else if (select_win != 4'd0) begin
      select_disc = 1'b1;
    end

    confirm_pend_d = confirm_pend_q;
    if (!confirm_pend_q || consume_tick) begin
      confirm_pend_d = press[8];
    end else if (press[8]) begin
      confirm_disc = 1'b1;
    end

    reset_total_pend_d = reset_total_pend_q;
    if (!reset_total_pend_q || consume_tick) begin
      reset_total_pend_d = press[9];
    end else if (press[9]) begin
      reset_total_disc = 1'b1;
    end

    overrun_d = coin_disc | select_disc | confirm_disc | reset_total_disc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q            <= '0;
      sync2_q            <= '0;
      stable_q           <= '0;
      coin_pend_q        <= '0;
      select_pend_q      <= '0;
      confirm_pend_q     <= 1'b0;
      reset_total_pend_q <= 1'b0;
      overrun_q          <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q            <= sync1_d;
      sync2_q            <= sync2_d;
      stable_q           <= stable_d;
      coin_pend_q        <= coin_pend_d;
      select_pend_q      <= select_pend_d;
      confirm_pend_q     <= confirm_pend_d;
      reset_total_pend_q <= reset_total_pend_d;
      overrun_q          <= overrun_d;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign coin_evt        = coin_pend_q;
  assign select_evt      = select_pend_q;
  assign confirm_evt     = confirm_pend_q;
  assign reset_total_evt = reset_total_pend_q;
  assign overrun         = overrun_q;

endmodule
